// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shifter with valid/ready load; PISO_PARITY_EN appends even parity
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned LAST_CNT = WIDTH;
`else
    localparam int unsigned LAST_CNT = WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(LAST_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAST_CNT);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CNT_W-1:0] cnt;
    logic             last_cyc;
    logic             handshake;
    logic             sr_bit;
    logic             data_bit;

    assign last_cyc   = (cnt == '0);
    assign load_ready = (state == S_IDLE) || last_cyc;
    assign handshake  = load_valid && load_ready;

    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    assign sr_bit     = MSB_FIRST ? sr[WIDTH-1] : sr[0];

    // Handshake is only possible in IDLE or on the last bit, so it takes priority over shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (handshake) begin
            state <= S_SHIFT;
            sr    <= parallel_in;
            cnt   <= CNT_LOAD;
        end else if (state == S_SHIFT) begin
            if (!last_cyc) begin
                sr  <= sr_shifted;
                cnt <= cnt - CNT_W'(1);
            end else begin
                state <= S_IDLE;
            end
        end
    end

`ifdef PISO_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (handshake) begin
            par_bit <= ^parallel_in;
        end
    end

    // Counter value 0 marks the appended parity cycle.
    assign data_bit = last_cyc ? par_bit : sr_bit;
`else
    assign data_bit = sr_bit;
`endif

    assign busy         = (state == S_SHIFT);
    assign serial_valid = busy;
    assign done         = busy && last_cyc;
    assign serial_out   = busy ? data_bit : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (8-bit MSB-first and 4-bit LSB-first)
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv8 = 1'b0, lr8, so8, sv8, busy8, done8;
    logic [7:0] pi8 = 8'h00;
    logic       lv4 = 1'b0, lr4, so4, sv4, busy4, done4;
    logic [3:0] pi4 = 4'h0;

    typedef struct {
        logic b;
        logic last;
    } bit_t;

    bit_t q8[$];
    bit_t q4[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs8     = 0;
    int   hs4     = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(lr8), .parallel_in(pi8),
        .serial_out(so8), .serial_valid(sv8), .busy(busy8), .done(done8)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_ready(lr4), .parallel_in(pi4),
        .serial_out(so4), .serial_valid(sv4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame8(input logic [7:0] d);
        for (int i = 0; i < 8; i++) q8.push_back('{b: d[7-i], last: (i == 7) && !PAR});
        if (PAR) q8.push_back('{b: ^d, last: 1'b1});
    endtask

    task automatic push_frame4(input logic [3:0] d);
        for (int i = 0; i < 4; i++) q4.push_back('{b: d[i], last: (i == 3) && !PAR});
        if (PAR) q4.push_back('{b: ^d, last: 1'b1});
    endtask

    task automatic mon8();
        bit_t e;
        logic v;
        v = (q8.size() != 0);
        e = '{b: 1'b0, last: 1'b0};
        if (v) e = q8.pop_front();
        check("d8_valid", sv8, v);
        check("d8_busy", busy8, v);
        check("d8_out", so8, e.b);
        check("d8_done", done8, v && e.last);
        check("d8_ready", lr8, !v || e.last);
    endtask

    task automatic mon4();
        bit_t e;
        logic v;
        v = (q4.size() != 0);
        e = '{b: 1'b0, last: 1'b0};
        if (v) e = q4.pop_front();
        check("d4_valid", sv4, v);
        check("d4_busy", busy4, v);
        check("d4_out", so4, e.b);
        check("d4_done", done4, v && e.last);
        check("d4_ready", lr4, !v || e.last);
    endtask

    // Model is ready when nothing remains queued after the current bit; a handshake then queues the frame.
    task automatic tick();
        if (!rst && lv8 && q8.size() == 0) begin
            push_frame8(pi8);
            hs8++;
        end
        if (!rst && lv4 && q4.size() == 0) begin
            push_frame4(pi4);
            hs4++;
        end
        @(negedge clk);
        mon8();
        mon4();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q8.size() != 0 || q4.size() != 0); i++) tick();
        check("drain_timeout", (q8.size() == 0) && (q4.size() == 0), 1'b1);
        repeat (2) tick();
    endtask

    initial begin
        int h;

        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();

        pi8 = 8'hB4;
        lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        pi8 = 8'h5A;
        drain();

        pi4 = 4'b1101;
        lv4 = 1'b1;
        tick();
        lv4 = 1'b0;
        drain();

        pi8 = 8'hA5;
        lv8 = 1'b1;
        h   = hs8;
        tick();
        pi8 = 8'h3C;
        for (int i = 0; i < 30 && hs8 < h + 2; i++) tick();
        lv8 = 1'b0;
        drain();

        pi8 = 8'h00;
        lv8 = 1'b1;
        h   = hs8;
        tick();
        lv8 = 1'b0;
        repeat (2) tick();
        pi8 = 8'hFF;
        lv8 = 1'b1;
        for (int i = 0; i < 30 && hs8 < h + 2; i++) tick();
        lv8 = 1'b0;
        drain();

        pi8 = 8'hB4;
        lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("arst_valid", sv8, 1'b0);
        check("arst_busy", busy8, 1'b0);
        check("arst_done", done8, 1'b0);
        check("arst_ready", lr8, 1'b1);
        check("arst_out", so8, 1'b0);
        q8.delete();
        q4.delete();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        pi8 = 8'hC3;
        pi4 = 4'b0110;
        lv8 = 1'b1;
        lv4 = 1'b1;
        tick();
        lv8 = 1'b0;
        lv4 = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, replacing the fixed 4-bit load-and-shift PISO.
- Accepts a WIDTH-bit word, then emits it one bit per clock, MSB or LSB first.
- Flags each valid serial bit and pulses on the last bit of a frame.
- Supports back-to-back frames with no idle gap.
- Sits between a parallel data source and a single-wire serial link or transmitter.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
IDLE_LEVEL, 0, value driven on serial_out when no frame is active.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  source has a word on parallel_in.
load_ready  output  1  block can accept a word this cycle.
parallel_in  input  WIDTH  word to serialise; sampled only on handshake.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a frame bit this cycle.
busy  output  1  a frame is in progress (state SHIFT).
done  output  1  single-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset (async, rst=1):
  - State -> IDLE; shift register -> 0; bit counter -> 0.
  - Outputs: load_ready=1, serial_out=IDLE_LEVEL, serial_valid=0, busy=0, done=0.
  - Reset mid-frame aborts the frame immediately; no done pulse; remaining bits are lost.
- State machine with two states, IDLE and SHIFT:
  - IDLE: load_ready=1. A handshake (load_valid && load_ready at rising edge) captures parallel_in into the shift register, sets the counter to WIDTH-1 and moves to SHIFT.
  - SHIFT with counter != 0: shift one position toward the output end each clock, decrement the counter. load_ready=0; load_valid is ignored.
  - SHIFT with counter == 0 (last bit): load_ready=1 and done=1.
    - If a handshake occurs on this edge: reload the register, counter -> WIDTH-1, stay in SHIFT. This gives gapless back-to-back frames.
    - Otherwise: go to IDLE.
- Outputs are decoded from registers only; no combinational path from inputs to outputs.
  - serial_out = MSB_FIRST ? sr[WIDTH-1] : sr[0] when in SHIFT; IDLE_LEVEL when in IDLE.
  - serial_valid = busy = (state == SHIFT).
  - load_ready = IDLE || (SHIFT && counter == 0).
- Latency and framing:
  - The first bit appears the cycle after the handshake edge.
  - A frame occupies exactly WIDTH consecutive cycles with serial_valid=1.
- Vacated bits fill with 0. The fill value is never visible on serial_out.
- Counter width is $clog2(WIDTH).
- parallel_in changes outside a handshake have no effect.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - One even-parity bit (XOR of the captured word) is appended after the data bits.
  - The frame is WIDTH+1 cycles long; the counter loads WIDTH.
  - done and load_ready=1 occur on the parity-bit cycle, not the last data bit.
  - Parity is computed at capture and held in a dedicated register.
- When undefined: no parity logic exists; frames are WIDTH cycles, exactly as above.

Test Plan:
1. Reset then idle: rst pulse, load_valid=0 for 10 cycles -> load_ready=1, serial_out=IDLE_LEVEL (0), serial_valid=0, busy=0, done=0 throughout.
2. Single frame, WIDTH=8, MSB_FIRST=1, load 8'hB4 -> serial_out sequence 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting the cycle after the handshake; done only on the 8th bit; then IDLE.
3. LSB-first, WIDTH=4, MSB_FIRST=0, load 4'b1101 -> sequence 1,0,1,1; serial_valid high exactly 4 cycles.
4. Back-to-back, WIDTH=8: load_valid held high with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100; busy never drops; done pulses on bits 8 and 16.
5. Load blocked mid-frame: load_valid=1 with 8'hFF on cycle 3 of an 8'h00 frame -> ignored (load_ready=0); output stays all zeros; 8'hFF is accepted only at the done cycle if still presented.
6. Async reset mid-frame: assert rst between clock edges during bit 4 -> outputs return to reset values immediately without waiting for an edge; no done pulse. With PISO_PARITY_EN defined, 8'hB4 -> 9 bits, 9th bit = 0 (four ones), done on bit 9.
